// File: rtl/apb_master_param.sv
// APB master bridging a simple CPU request port onto NUM_SLAVES APB slaves.
// The address window starting at BASE_ADDR is split into equal 2**SLOT_SHIFT
// regions, one per slave; anything outside the window completes at once with
// an error. A stalled slave is abandoned after TIMEOUT ACCESS cycles.
module apb_master_param #(
    parameter int          NUM_SLAVES = 5,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          SLOT_SHIFT = 12,
    parameter int          TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         error,
    output logic [31:0]                  PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_SETUP  = 2'd1;
    localparam logic [1:0]  ST_ACCESS = 2'd2;
    localparam logic [1:0]  ST_DECERR = 2'd3;

    // Size of the decoded window; one bit wider so BASE_ADDR near the top
    // of the address space cannot wrap.
    localparam logic [32:0] WINDOW    = 33'(NUM_SLAVES) << SLOT_SHIFT;
    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [7:0]            tmo_cnt_r;
    logic [31:0]           paddr_r;
    logic                  pwrite_r;
    logic [DATA_W-1:0]     pwdata_r;
    logic [NUM_SLAVES-1:0] psel_r;
    logic                  penable_r;

    logic [31:0]           req_off_s;
    logic                  req_mapped_s;
    logic [NUM_SLAVES-1:0] req_psel_s;
    logic [DATA_W-1:0]     sel_rdata_s;
    logic                  sel_pready_s;
    logic                  sel_pslverr_s;
    logic                  done_ok_s;
    logic                  done_tmo_s;

    // Decode the request address into a mapped flag and a one-hot select.
    always_comb begin
        req_off_s    = addr - BASE_ADDR;
        req_mapped_s = (addr >= BASE_ADDR) && ({1'b0, req_off_s} < WINDOW);
        req_psel_s   = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if ((req_off_s >> SLOT_SHIFT) == 32'(i)) begin
                req_psel_s[i] = 1'b1;
            end else begin
                req_psel_s[i] = 1'b0;
            end
        end
    end

    // Steer the selected slave's response; unselected slaves are masked out.
    always_comb begin
        sel_rdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata_s = sel_rdata_s | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{psel_r[i]}});
        end
        sel_pready_s  = |(PREADY & psel_r);
        sel_pslverr_s = |(PSLVERR & psel_r);
    end

    // Completion conditions; a ready slave wins over the timeout.
    always_comb begin
        done_ok_s  = (state_r == ST_ACCESS) && sel_pready_s;
        done_tmo_s = (state_r == ST_ACCESS) && !sel_pready_s && (tmo_cnt_r == TO_LAST);
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (transfer) begin
                    state_nxt_s = req_mapped_s ? ST_SETUP : ST_DECERR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (done_ok_s || done_tmo_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DECERR: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // APB request registers and the ACCESS timeout counter.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            paddr_r   <= 32'h0000_0000;
            pwrite_r  <= 1'b0;
            pwdata_r  <= {DATA_W{1'b0}};
            psel_r    <= {NUM_SLAVES{1'b0}};
            penable_r <= 1'b0;
            tmo_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (transfer) begin
                        paddr_r  <= addr;
                        pwrite_r <= write;
                        pwdata_r <= wdata;
                        psel_r   <= req_mapped_s ? req_psel_s : {NUM_SLAVES{1'b0}};
                    end else begin
                        psel_r   <= {NUM_SLAVES{1'b0}};
                    end
                    penable_r <= 1'b0;
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    tmo_cnt_r <= 8'd0;
                end
                ST_ACCESS: begin
                    if (done_ok_s || done_tmo_s) begin
                        psel_r    <= {NUM_SLAVES{1'b0}};
                        penable_r <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                default: begin
                    psel_r    <= {NUM_SLAVES{1'b0}};
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    // CPU-side response: completion status must appear in the same cycle
    // the slave answers, so this is decoded from state and slave inputs.
    always_comb begin
        ready = 1'b0;
        error = 1'b0;
        rdata = {DATA_W{1'b0}};
        case (state_r)
            ST_ACCESS: begin
                if (done_ok_s) begin
                    ready = 1'b1;
                    error = sel_pslverr_s;
                    rdata = sel_rdata_s;
                end else if (done_tmo_s) begin
                    ready = 1'b1;
                    error = 1'b1;
                    rdata = {DATA_W{1'b0}};
                end else begin
                    ready = 1'b0;
                    error = 1'b0;
                    rdata = {DATA_W{1'b0}};
                end
            end
            ST_DECERR: begin
                ready = 1'b1;
                error = 1'b1;
                rdata = {DATA_W{1'b0}};
            end
            default: begin
                ready = 1'b0;
                error = 1'b0;
                rdata = {DATA_W{1'b0}};
            end
        endcase
    end

    assign PADDR   = paddr_r;
    assign PWRITE  = pwrite_r;
    assign PWDATA  = pwdata_r;
    assign PSEL    = psel_r;
    assign PENABLE = penable_r;

endmodule

// File: tb/tb_apb_master_param.sv
// Directed bench for apb_master_param with a transaction-level latency model.
module tb_apb_master_param;

    localparam int NS  = 5;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           transfer;
    logic           write;
    logic [31:0]    addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    logic           ready;
    logic           error;
    logic [31:0]    PADDR;
    logic           PWRITE;
    logic           PENABLE;
    logic [DW-1:0]  PWDATA;
    logic [NS-1:0]  PSEL;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  PSLVERR;

    int checks = 0;
    int errors = 0;

    // Transaction descriptor and expected APB-side register contents.
    logic        m_active;
    logic [31:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    int          m_waits;
    logic        m_slverr;
    logic [31:0] m_rval;
    int          m_off;
    logic [31:0] m_paddr;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic        chk_en;

    // Values expected / captured by the compare process.
    logic [NS-1:0] e_psel;
    logic          e_pen;
    logic          e_rdy;
    logic          e_err;
    logic [31:0]   e_rd;
    int            acc_len;
    logic          timed_out;
    int            rdy_off;
    logic          cap_err;
    logic [31:0]   cap_rdata;
    logic [31:0]   cap_paddr;
    logic [NS-1:0] cap_psel;

    apb_master_param #(
        .NUM_SLAVES(NS), .DATA_W(DW), .BASE_ADDR(32'h1000_0000),
        .SLOT_SHIFT(12), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .error(error),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    function automatic bit is_mapped(input logic [31:0] a);
        return (a >= 32'h1000_0000) && (a < 32'h1000_5000);
    endfunction

    function automatic int slave_of(input logic [31:0] a);
        return int'((a - 32'h1000_0000) / 32'h0000_1000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the latency model on every falling edge.
    always @(negedge PCLK) begin
        if (chk_en) begin
            e_psel = 5'b00000;
            e_pen  = 1'b0;
            e_rdy  = 1'b0;
            e_err  = 1'b0;
            e_rd   = 32'h0;
            if (m_active && m_off > 0) begin
                if (!is_mapped(m_addr)) begin
                    if (m_off == 1) begin
                        e_rdy = 1'b1;
                        e_err = 1'b1;
                    end
                end else begin
                    acc_len   = (m_waits + 1 < TMO) ? m_waits + 1 : TMO;
                    timed_out = (m_waits + 1 > TMO);
                    if (m_off <= acc_len + 1) begin
                        e_psel = 5'b00001 << slave_of(m_addr);
                        e_pen  = (m_off >= 2);
                    end
                    if (m_off == acc_len + 1) begin
                        e_rdy = 1'b1;
                        e_err = timed_out ? 1'b1 : m_slverr;
                        e_rd  = timed_out ? 32'h0 : m_rval;
                    end
                end
            end
            check("psel",    64'(PSEL),    64'(e_psel));
            check("penable", 64'(PENABLE), 64'(e_pen));
            check("ready",   64'(ready),   64'(e_rdy));
            check("error",   64'(error),   64'(e_err));
            check("rdata",   64'(rdata),   64'(e_rd));
            check("paddr",   64'(PADDR),   64'(m_paddr));
            check("pwrite",  64'(PWRITE),  64'(m_pwrite));
            check("pwdata",  64'(PWDATA),  64'(m_pwdata));
            if (m_active && m_off == 0) begin
                cap_psel = 5'b00000;
                rdy_off  = -1;
            end
            cap_psel = cap_psel | PSEL;
            if (ready) begin
                rdy_off   = m_off;
                cap_err   = error;
                cap_rdata = rdata;
                cap_paddr = PADDR;
            end
        end
    end

    task automatic drive_slaves(input bit mp, input int idx, input bit rdy_tgt,
                                input logic serr, input logic [31:0] rv);
        for (int i = 0; i < NS; i++) begin
            if (mp && i == idx) begin
                PREADY[i]            = rdy_tgt;
                PSLVERR[i]           = serr;
                PRDATA[i*DW +: DW]   = rv;
            end else begin
                PREADY[i]            = 1'b1;
                PSLVERR[i]           = 1'b1;
                PRDATA[i*DW +: DW]   = 32'hBAD0_0000 | 32'(i);
            end
        end
    endtask

    // One full transaction from the transfer-sampled cycle to completion.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input int waits, input logic serr, input logic [31:0] rv);
        bit mp;
        int total;
        mp    = is_mapped(a);
        total = mp ? 2 + ((waits + 1 < TMO) ? waits + 1 : TMO) : 2;
        m_active = 1'b1; m_addr = a; m_write = w; m_wdata = wd;
        m_waits = waits; m_slverr = serr; m_rval = rv;
        for (int off = 0; off < total; off++) begin
            m_off = off;
            transfer = 1'b1;
            if (off == 0) begin
                addr = a; write = w; wdata = wd;
            end else begin
                // Request lines change under an active transfer; must be ignored.
                addr = 32'h1000_0000; write = ~w; wdata = ~wd;
                m_paddr = a; m_pwrite = w; m_pwdata = wd;
            end
            drive_slaves(mp, mp ? slave_of(a) : 0, (off >= 2) && (off - 2 >= waits), serr, rv);
            @(posedge PCLK); #1;
        end
    endtask

    task automatic idle(input int n);
        m_active = 1'b0;
        transfer = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        chk_en = 1'b0; m_active = 1'b0; m_off = 0;
        m_paddr = 32'h0; m_pwrite = 1'b0; m_pwdata = 32'h0;
        m_addr = 32'h0; m_write = 1'b0; m_wdata = 32'h0; m_waits = 0; m_slverr = 1'b0; m_rval = 32'h0;
        cap_psel = 5'b00000; rdy_off = -1; cap_err = 1'b0; cap_rdata = 32'h0; cap_paddr = 32'h0;
        transfer = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
        PREADY = 5'b11111; PSLVERR = 5'b00000; PRDATA = '0;
        PRESET = 1'b1;
        #1 PRESET = 1'b0;
        #1;
        check("rst_psel",  64'(PSEL),    64'h0);
        check("rst_ready", 64'(ready),   64'h0);
        check("rst_paddr", 64'(PADDR),   64'h0);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Write to slave 1, zero wait.
        run_txn(32'h1000_1000, 1'b1, 32'h0000_00A5, 0, 1'b0, 32'h1111_1111);
        check("s1_psel",   64'(cap_psel),  64'(5'b00010));
        check("s1_lat",    64'(rdy_off),   64'd2);
        check("s1_err",    64'(cap_err),   64'd0);
        check("s1_pwdata", 64'(PWDATA),    64'h0000_00A5);
        idle(2);

        // Read slave 4 with three wait states.
        run_txn(32'h1000_4008, 1'b0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
        check("s4_lat",    64'(rdy_off),   64'd5);
        check("s4_rdata",  64'(cap_rdata), 64'hDEAD_BEEF);
        check("s4_paddr",  64'(cap_paddr), 64'h1000_4008);
        idle(1);

        // Unmapped just past the window.
        run_txn(32'h1000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        check("dec_lat",   64'(rdy_off),   64'd1);
        check("dec_err",   64'(cap_err),   64'd1);
        check("dec_rdata", 64'(cap_rdata), 64'h0);
        check("dec_psel",  64'(cap_psel),  64'h0);
        idle(1);

        // Unmapped just below the window.
        run_txn(32'h0FFF_FFFC, 1'b1, 32'h77, 0, 1'b0, 32'h0);
        check("below_lat", 64'(rdy_off),   64'd1);
        idle(1);

        // Slave 2 never ready: abort on the 16th ACCESS cycle.
        run_txn(32'h1000_2000, 1'b0, 32'h0, 1000, 1'b0, 32'hCAFE_0002);
        check("tmo_lat",   64'(rdy_off),   64'd17);
        check("tmo_err",   64'(cap_err),   64'd1);
        check("tmo_rdata", 64'(cap_rdata), 64'h0);
        idle(2);

        // Ready arrives exactly in the timeout cycle: normal completion wins.
        run_txn(32'h1000_0FFC, 1'b0, 32'h0, TMO - 1, 1'b0, 32'h5555_AAAA);
        check("edge_lat",  64'(rdy_off),   64'd17);
        check("edge_err",  64'(cap_err),   64'd0);
        check("edge_rd",   64'(cap_rdata), 64'h5555_AAAA);
        idle(1);

        // Slave 3 answers with an error.
        run_txn(32'h1000_3000, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h3333_3333);
        check("s3_lat",    64'(rdy_off),   64'd2);
        check("s3_err",    64'(cap_err),   64'd1);
        idle(1);

        // Back-to-back: transfer held high through completion.
        run_txn(32'h1000_1004, 1'b0, 32'h0, 1, 1'b0, 32'h0102_0304);
        check("b2b1_rd",   64'(cap_rdata), 64'h0102_0304);
        run_txn(32'h1000_0010, 1'b1, 32'h0A0B_0C0D, 0, 1'b0, 32'h0);
        check("b2b2_lat",  64'(rdy_off),   64'd2);
        idle(2);

        // Reset asserted in ACCESS aborts the transfer.
        chk_en = 1'b0;
        transfer = 1'b1; addr = 32'h1000_2000; write = 1'b1; wdata = 32'h5A;
        PREADY = 5'b11011; PSLVERR = 5'b00000;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(posedge PCLK); #1;
        check("ra_psel",   64'(PSEL),      64'(5'b00100));
        check("ra_pen",    64'(PENABLE),   64'd1);
        #2 PRESET = 1'b0;
        #1;
        check("rz_psel",   64'(PSEL),      64'h0);
        check("rz_pen",    64'(PENABLE),   64'h0);
        check("rz_ready",  64'(ready),     64'h0);
        check("rz_paddr",  64'(PADDR),     64'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        m_paddr = 32'h0; m_pwrite = 1'b0; m_pwdata = 32'h0; m_active = 1'b0;
        chk_en = 1'b1;
        run_txn(32'h1000_0000, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0);
        check("rr_lat",    64'(rdy_off),   64'd2);
        check("rr_psel",   64'(cap_psel),  64'(5'b00001));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
